// File: rtl/alu_multdiv.sv
// Iterative multiply/divide unit owning the HI/LO registers: shift-add multiply,
// restoring divide, one bit per cycle, fixed 33-edge latency from start to result.
module alu_multdiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             write_hi,
  input  logic             write_lo,
  input  logic [WIDTH-1:0] write_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           op_q;
  logic [WIDTH-1:0]     operand_q;   // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0]   acc_q;       // {upper, lower} product or {remainder, quotient}
  logic                 neg_main_q;  // negate product / quotient
  logic                 neg_rem_q;   // negate remainder
  logic                 div_zero_q;
  logic [CNT_W-1:0]     count_q;
  logic                 done_q;
  logic [WIDTH-1:0]     hi_q, lo_q;

  logic [WIDTH-1:0]     abs_a, abs_b;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       div_shift;
  logic [WIDTH+1:0]     div_diff;
  logic [2*WIDTH-1:0]   div_next;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;
  logic                 last_iter;

  assign abs_a = (op[0] && a[WIDTH-1]) ? -a : a;
  assign abs_b = (op[0] && b[WIDTH-1]) ? -b : b;

  // Multiply: add multiplicand into the upper half when the low bit is set, then shift right.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, operand_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Restoring divide: the remainder never exceeds WIDTH bits once the trial subtract resolves.
  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff  = {1'b0, div_shift} - {2'b00, operand_q};
  assign div_next  = div_diff[WIDTH+1] ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                       : {div_diff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};

  assign prod_fix  = neg_main_q ? -acc_q : acc_q;
  assign quo_fix   = div_zero_q ? '1
                   : (neg_main_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
  assign rem_fix   = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  assign last_iter = (count_q == CNT_W'(WIDTH - 1));

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start)     state_d = CALC;
      CALC:    if (last_iter) state_d = FIX;
      FIX:                    state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q       <= '0;
      operand_q  <= '0;
      acc_q      <= '0;
      neg_main_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      count_q    <= '0;
      done_q     <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (write_hi) hi_q <= write_data;
          if (write_lo) lo_q <= write_data;
          if (start) begin
            op_q       <= op;
            operand_q  <= op[1] ? abs_b : abs_a;
            acc_q      <= {{WIDTH{1'b0}}, (op[1] ? abs_a : abs_b)};
            neg_main_q <= op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_rem_q  <= op[0] & a[WIDTH-1];
            div_zero_q <= op[1] & (b == '0);
            count_q    <= '0;
          end
        end
        CALC: begin
          acc_q   <= op_q[1] ? div_next : mul_next;
          count_q <= count_q + CNT_W'(1);
        end
        FIX: begin
          if (op_q[1]) begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end else begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_alu_multdiv.sv
// Self-checking bench for alu_multdiv: directed cases plus randomized ops checked
// against an arithmetic reference model of the MIPS HI/LO results.
module tb_alu_multdiv;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         write_hi, write_lo;
  logic [W-1:0] write_data;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_hi = '0, exp_lo = '0;

  alu_multdiv #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .write_hi(write_hi), .write_lo(write_lo), .write_data(write_data),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference: {hi, lo} from plain arithmetic on the operands.
  function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [W-1:0] x,
                                             input logic [W-1:0] y);
    longint unsigned ux, uy;
    longint sx, sy;
    ux = x; uy = y;
    sx = longint'(signed'(x)); sy = longint'(signed'(y));
    case (o)
      2'b00: return ux * uy;
      2'b01: return sx * sy;
      2'b10: if (y == 0) return {x, 32'hFFFF_FFFF};
             else return {W'(ux % uy), W'(ux / uy)};
      default: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        return {W'(sx % sy), W'(sx / sy)};
      end
    endcase
  endfunction

  // Issue one op; optionally disturb inputs mid-run. Checks latency, busy, hold, result.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input bit disturb);
    logic [63:0] exp;
    int          edge_n;
    bit          busy_bad, hold_bad;
    int          extra_done;
    exp = ref_result(o, x, y);
    busy_bad = 0; hold_bad = 0; extra_done = 0; edge_n = 0;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom);
    while (edge_n < 40) begin
      @(posedge clk);
      edge_n++;
      @(negedge clk);
      if (disturb && edge_n == 5) begin
        start = 1'b1; write_hi = 1'b1; write_lo = 1'b1; write_data = 32'hDEAD;
      end else begin
        start = 1'b0; write_hi = 1'b0; write_lo = 1'b0;
      end
      if (done) break;
      if (!busy) busy_bad = 1;
      if (hi !== exp_hi || lo !== exp_lo) hold_bad = 1;
    end
    start = 1'b0; write_hi = 1'b0; write_lo = 1'b0;
    check({tag, " latency"}, 64'(edge_n), 64'd33);
    check({tag, " busy_during"}, 64'(busy_bad), 64'd0);
    check({tag, " hold_during"}, 64'(hold_bad), 64'd0);
    check({tag, " busy_at_done"}, 64'(busy), 64'd0);
    check({tag, " result"}, {hi, lo}, exp);
    exp_hi = exp[63:32]; exp_lo = exp[31:0];
    @(negedge clk);
    check({tag, " done_pulse"}, 64'(done), 64'd0);
    if (disturb) begin
      repeat (40) begin
        @(negedge clk);
        if (done) extra_done++;
      end
      check({tag, " extra_done"}, 64'(extra_done), 64'd0);
    end
  endtask

  initial begin
    logic [W-1:0] specials [5];
    specials = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    write_hi = 1'b0; write_lo = 1'b0; write_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {busy, done, hi, lo}, '0);
    @(negedge clk);
    reset = 1'b0;

    run_op("multu_ff_x2", 2'b00, 32'hFFFF_FFFF, 32'h2, 0);
    check("multu_ff_x2 lit", {hi, lo}, {32'h1, 32'hFFFF_FFFE});
    run_op("mult_m7_x3", 2'b01, 32'hFFFF_FFF9, 32'd3, 0);
    check("mult_m7_x3 lit", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFEB});
    run_op("div_m7_2", 2'b11, 32'hFFFF_FFF9, 32'd2, 0);
    check("div_m7_2 lit", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op("divu_10_2", 2'b10, 32'd10, 32'd2, 0);
    check("divu_10_2 lit", {hi, lo}, {32'd0, 32'd5});
    run_op("divu_by0", 2'b10, 32'd25, 32'd0, 0);
    check("divu_by0 lit", {hi, lo}, {32'd25, 32'hFFFF_FFFF});
    run_op("div_by0_neg", 2'b11, 32'hFFFF_FF00, 32'd0, 0);
    run_op("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    check("div_ovf lit", {hi, lo}, {32'd0, 32'h8000_0000});
    run_op("multu_disturb", 2'b00, 32'd10, 32'd2, 1);
    check("multu_disturb lit", {hi, lo}, {32'd0, 32'd20});

    // MTHI/MTLO together in IDLE, then hold.
    @(negedge clk);
    write_hi = 1'b1; write_lo = 1'b1; write_data = 32'h1234;
    @(negedge clk);
    write_hi = 1'b0; write_lo = 1'b0; write_data = 32'h5555;
    check("mt_write", {hi, lo}, {32'h1234, 32'h1234});
    exp_hi = 32'h1234; exp_lo = 32'h1234;
    begin
      bit hold_bad = 0;
      repeat (10) begin
        @(negedge clk);
        if (hi !== exp_hi || lo !== exp_lo || busy || done) hold_bad = 1;
      end
      check("mt_hold", 64'(hold_bad), 64'd0);
    end
    @(negedge clk);
    write_hi = 1'b1; write_data = 32'hCAFE;
    @(negedge clk);
    write_hi = 1'b0;
    check("mthi_only", {hi, lo}, {32'hCAFE, 32'h1234});
    exp_hi = 32'hCAFE;

    // Reset in the middle of a DIV run.
    @(negedge clk);
    start = 1'b1; op = 2'b11; a = 32'hFFFF_FFF9; b = 32'd2;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("midop_reset", {busy, done, hi, lo}, '0);
    exp_hi = '0; exp_lo = '0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_idle", {busy, done, hi, lo}, '0);
    run_op("multu_3x4", 2'b00, 32'd3, 32'd4, 0);
    check("multu_3x4 lit", {hi, lo}, {32'd0, 32'd12});

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] x, y;
      x = (($urandom % 4) == 0) ? specials[$urandom % 5] : W'($urandom);
      y = (($urandom % 4) == 0) ? specials[$urandom % 5] : W'($urandom);
      if (($urandom % 3) == 0) y = W'($urandom_range(0, 15));
      run_op($sformatf("rand%0d", i), 2'($urandom), x, y, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1);
  end

endmodule

// File: doc/alu_multdiv.md
Name: alu_multdiv

Overview:
- Multi-cycle multiply/divide responder for the MIPS CPU datapath.
- Serves MULT, MULTU, DIV and DIVU requests issued by the control unit. Single-cycle ALU operations continue to be handled by the ALU.
- Owns the HI/LO registers. Accepts direct HI/LO writes for MTHI/MTLO.
- Uses an iterative, one-bit-per-cycle algorithm with a start/busy/done handshake.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 6, iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request strobe; sampled only in IDLE
- op  input  2  00=MULTU, 01=MULT, 10=DIVU, 11=DIV (signed ops are two's complement)
- a  input  WIDTH  multiplicand / dividend (rs)
- b  input  WIDTH  multiplier / divisor (rt)
- write_hi  input  1  MTHI strobe
- write_lo  input  1  MTLO strobe
- write_data  input  WIDTH  data for MTHI/MTLO
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse; the new HI/LO are valid in this cycle
- hi  output  WIDTH  HI register (product upper half / remainder)
- lo  output  WIDTH  LO register (product lower half / quotient)

Behaviour:
- Reset (async, active-high): state=IDLE; hi=0, lo=0, busy=0, done=0, counter=0. Reset asserted mid-operation aborts it immediately; no partial result reaches hi/lo.
- States: IDLE, CALC, FIX.
- IDLE, start=1 at edge E0:
  - latch op; latch |a|, |b| (signed ops) or a, b (unsigned ops)
  - record the result signs: product sign = a[31]^b[31]; quotient sign = a[31]^b[31]; remainder sign = a[31]
  - counter=0, busy=1, state→CALC
- CALC: one iteration per edge, edges E1..E32.
  - Multiply: shift-add on a 64-bit accumulator.
  - Divide: restoring division; shift the remainder left, subtract the divisor, keep the difference if non-negative, set the quotient bit.
  - After the 32nd iteration, state→FIX.
- FIX, edge E33:
  - apply two's-complement sign correction for signed ops
  - write hi/lo; done=1 and busy=0 in the following cycle
  - state→IDLE
- Latency: hi/lo are updated exactly 33 edges after the start edge, fixed for every op and every operand value. done is high for exactly one cycle.
- Inputs a and b are ignored after E0. Changing them mid-operation must not affect the result.
- start while busy: ignored, not queued.
- write_hi/write_lo:
  - In IDLE: update hi/lo at the next edge. Both may assert together.
  - While busy: ignored.
  - Same edge as an accepted start: the write takes effect, and the operation result later overwrites it.
- hi/lo hold their value at all times except on a FIX edge, an accepted MT write, or reset.
- Result rules:
  - MULTU/MULT: {hi,lo} = full 64-bit product, unsigned or signed.
  - DIVU/DIV: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - Divide by zero (any divide op): lo=32'hFFFFFFFF, hi=a (original operand), same 33-edge latency.
  - DIV overflow (a=32'h80000000, b=32'hFFFFFFFF): lo=32'h80000000, hi=0.
- done never asserts without a preceding accepted start. busy=0 in IDLE.

Test Plan:
- Reset, then MULTU a=32'hFFFFFFFF, b=32'h2 → done pulses once at edge 33; hi=32'h1, lo=32'hFFFFFFFE; busy high for edges 1..33.
- MULT a=-7 (32'hFFFFFFF9), b=3 → hi=32'hFFFFFFFF, lo=32'hFFFFFFEB. Then DIV a=-7, b=2 → lo=32'hFFFFFFFD, hi=32'hFFFFFFFF. Then DIVU a=10, b=2 → lo=5, hi=0.
- DIVU a=25, b=0 → lo=32'hFFFFFFFF, hi=32'd25 at edge 33. DIV a=32'h80000000, b=32'hFFFFFFFF → lo=32'h80000000, hi=0.
- Mid-operation disturbance: during a MULTU 10×2 run, change a and b, pulse start again, and pulse write_hi with write_data=32'hDEAD. The result must still be hi=0, lo=20, with exactly one done pulse.
- MTHI/MTLO in IDLE: write_hi and write_lo together with write_data=32'h1234 → hi=lo=32'h1234 the next cycle; hi/lo then hold for 10 idle cycles.
- Assert reset at edge 15 of a DIV run → busy=0, done=0, hi=lo=0 immediately. After release, a new MULTU 3×4 gives lo=12 at edge 33.
